// File: rtl/factorization_pkg.sv
// rtl/factorization_pkg.sv - shared game states, judgement codes and arbiter FSM type
package factorization_pkg;

  localparam logic [3:0] ST_INIT   = 4'b0001;
  localparam logic [3:0] ST_READY  = 4'b0010;
  localparam logic [3:0] ST_INPUT  = 4'b0100;
  localparam logic [3:0] ST_SHOW   = 4'b1000;

  localparam logic [1:0] J_NONE = 2'b00;
  localparam logic [1:0] J_P1   = 2'b01;
  localparam logic [1:0] J_P2   = 2'b10;
  localparam logic [1:0] J_DRAW = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CHECK,
    ARB_WINDOW,
    ARB_RESULT
  } arb_state_t;

  // Player index (0 = P1, 1 = P2) to the one-hot code used on JUDG/WRONG_WHO.
  function automatic logic [1:0] player_onehot(input logic p);
    return p ? J_P2 : J_P1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a pointer that toggles on every grant
module rr_arb2
  import factorization_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // Single requester wins outright; a tie goes to the pointer player.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o != 2'b00) begin
      ptr_d = ~ptr_q;
    end
  end

  // Pointer register; starts on P1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/answer_arbiter.sv
// rtl/answer_arbiter.sv - shares the factor checker between two players, orders checks and judges with a draw window (option: ANSWER_LOCKOUT_EN)
module answer_arbiter
  import factorization_pkg::*;
#(
  parameter int ANS_W    = 8,
  parameter int DRAW_WIN = 16,
  parameter int CHK_TMO  = 255
`ifdef ANSWER_LOCKOUT_EN
  , parameter int LOCK_CYC = 50_000_000
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       STATE_IN,
  input  logic             REQ1,
  input  logic [ANS_W-1:0] ANS1,
  input  logic             REQ2,
  input  logic [ANS_W-1:0] ANS2,
  output logic             CHK_START,
  output logic [ANS_W-1:0] CHK_ANS,
  input  logic             CHK_DONE,
  input  logic             CHK_OK,
  output logic             BUSY,
  output logic [1:0]       JUDG,
  output logic             WRONG,
  output logic [1:0]       WRONG_WHO
);

  localparam int TMO_W = $clog2(CHK_TMO + 1);
  localparam int WIN_W = $clog2(DRAW_WIN + 1);

  arb_state_t       st_q, st_d;
  logic             from_win_q, from_win_d;
  logic             cur_q, cur_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       corr_q, corr_d;
  logic [ANS_W-1:0] ans1_q, ans1_d;
  logic [ANS_W-1:0] ans2_q, ans2_d;
  logic [ANS_W-1:0] chk_ans_q, chk_ans_d;
  logic             chk_start_q, chk_start_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [1:0]       judg_q, judg_d;
  logic             wrong_q, wrong_d;
  logic [1:0]       wrong_who_q, wrong_who_d;

  logic             in_input;
  logic [1:0]       cap;
  logic [1:0]       locked;
  logic [1:0]       gnt;
  logic             expired;
  logic             grant_en;
  logic             res_valid;
  logic             res_ok;
  logic             wrong_ev;

  assign in_input  = (STATE_IN == ST_INPUT);
  assign cap       = {REQ2, REQ1} & ~pend_q & ~corr_q & ~locked
                   & {2{in_input && (st_q != ARB_RESULT)}};
  assign expired   = (win_q == WIN_W'(DRAW_WIN));
  assign grant_en  = in_input && ((st_q == ARB_IDLE) || ((st_q == ARB_WINDOW) && !expired));
  // A timeout is treated exactly like a CHK_DONE with CHK_OK low.
  assign res_valid = (st_q == ARB_CHECK) && (CHK_DONE || (tmo_q == TMO_W'(CHK_TMO)));
  assign res_ok    = res_valid && CHK_DONE && CHK_OK;
  assign wrong_ev  = in_input && res_valid && !res_ok;

  // Requests include a submission captured this very cycle so a REQ in IDLE starts the checker next cycle.
  rr_arb2 u_rr (
    .CLK   (CLK),
    .RST   (RST),
    .req_i (pend_q | cap),
    .en_i  (grant_en),
    .gnt_o (gnt)
  );

`ifdef ANSWER_LOCKOUT_EN
  localparam int LK_W = $clog2(LOCK_CYC + 1);

  logic [1:0][LK_W-1:0] lock_q, lock_d;

  // Per-player lockout counters, loaded on WRONG and counting down to zero.
  always_comb begin
    lock_d = lock_q;
    for (int i = 0; i < 2; i++) begin
      if (lock_q[i] != '0) begin
        lock_d[i] = lock_q[i] - 1'b1;
      end
    end
    if (wrong_ev) begin
      lock_d[cur_q] = LK_W'(LOCK_CYC);
    end
    if (!in_input) begin
      lock_d = '0;
    end
  end

  // Lockout counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_q <= '0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign locked = {lock_q[1] != '0, lock_q[0] != '0};
`else
  assign locked = 2'b00;
`endif

  // Next-state: capture, grant, check result handling, draw window and leave-INPUT clear.
  always_comb begin
    st_d        = st_q;
    from_win_d  = from_win_q;
    cur_d       = cur_q;
    pend_d      = pend_q | cap;
    corr_d      = corr_q;
    ans1_d      = cap[0] ? ANS1 : ans1_q;
    ans2_d      = cap[1] ? ANS2 : ans2_q;
    chk_ans_d   = chk_ans_q;
    chk_start_d = 1'b0;
    tmo_d       = tmo_q;
    win_d       = win_q;
    judg_d      = judg_q;
    wrong_d     = 1'b0;
    wrong_who_d = wrong_who_q;

    if ((st_q == ARB_CHECK) && (tmo_q != TMO_W'(CHK_TMO))) begin
      tmo_d = tmo_q + 1'b1;
    end
    // The draw window keeps running while the other player's check is in flight.
    if (((st_q == ARB_WINDOW) || ((st_q == ARB_CHECK) && from_win_q)) && !expired) begin
      win_d = win_q + 1'b1;
    end

    case (st_q)
      ARB_IDLE, ARB_WINDOW: begin
        if ((st_q == ARB_WINDOW) && expired) begin
          judg_d = corr_q;
          st_d   = ARB_RESULT;
        end else if (gnt != 2'b00) begin
          st_d        = ARB_CHECK;
          from_win_d  = (st_q == ARB_WINDOW);
          cur_d       = gnt[1];
          chk_start_d = 1'b1;
          chk_ans_d   = gnt[1] ? ans2_d : ans1_d;
          tmo_d       = '0;
        end
      end
      ARB_CHECK: begin
        if (res_valid) begin
          pend_d[cur_q] = 1'b0;
          if (res_ok) begin
            corr_d[cur_q] = 1'b1;
          end else begin
            wrong_d     = 1'b1;
            wrong_who_d = player_onehot(cur_q);
          end
          if (from_win_q) begin
            if (res_ok && !expired) begin
              judg_d = J_DRAW;
              st_d   = ARB_RESULT;
            end else if (expired) begin
              judg_d = corr_q;
              st_d   = ARB_RESULT;
            end else begin
              st_d = ARB_WINDOW;
            end
          end else if (res_ok) begin
            st_d  = ARB_WINDOW;
            win_d = '0;
          end else begin
            st_d = ARB_IDLE;
          end
        end
      end
      default: begin
      end
    endcase

    // Leaving INPUT abandons everything except the round-robin pointer.
    if (!in_input) begin
      st_d        = ARB_IDLE;
      from_win_d  = 1'b0;
      pend_d      = 2'b00;
      corr_d      = 2'b00;
      chk_start_d = 1'b0;
      tmo_d       = '0;
      win_d       = '0;
      judg_d      = J_NONE;
      wrong_d     = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q        <= ARB_IDLE;
      from_win_q  <= 1'b0;
      cur_q       <= 1'b0;
      pend_q      <= 2'b00;
      corr_q      <= 2'b00;
      ans1_q      <= '0;
      ans2_q      <= '0;
      chk_ans_q   <= '0;
      chk_start_q <= 1'b0;
      tmo_q       <= '0;
      win_q       <= '0;
      judg_q      <= J_NONE;
      wrong_q     <= 1'b0;
      wrong_who_q <= 2'b00;
    end else begin
      st_q        <= st_d;
      from_win_q  <= from_win_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      corr_q      <= corr_d;
      ans1_q      <= ans1_d;
      ans2_q      <= ans2_d;
      chk_ans_q   <= chk_ans_d;
      chk_start_q <= chk_start_d;
      tmo_q       <= tmo_d;
      win_q       <= win_d;
      judg_q      <= judg_d;
      wrong_q     <= wrong_d;
      wrong_who_q <= wrong_who_d;
    end
  end

  assign CHK_START = chk_start_q;
  assign CHK_ANS   = chk_ans_q;
  assign BUSY      = (st_q == ARB_CHECK);
  assign JUDG      = judg_q;
  assign WRONG     = wrong_q;
  assign WRONG_WHO = wrong_who_q;

endmodule
